// File: rtl/lsu_sbuf_if.sv
// -----------------------------------------------------------------------------
// lsu_sbuf_if - D-Bus bundle between the load-store unit and the data memory.
//
//   o_DAddr  LSU -> mem  bus address (word/dword aligned)
//   o_DCmd   LSU -> mem  command valid, held until i_DRdy or i_DErr
//   o_DRnW   LSU -> mem  1 read, 0 write
//   o_DBen   LSU -> mem  byte enables, one per data byte
//   o_DData  LSU -> mem  write data, inactive lanes zero
//   i_DData  mem -> LSU  read data
//   i_DRdy   mem -> LSU  transaction complete
//   i_DErr   mem -> LSU  transaction error (wins over i_DRdy)
//
// master: the LSU side. slave: the memory / bus model side.
// -----------------------------------------------------------------------------
interface lsu_sbuf_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BEN = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] o_DAddr;
  logic                  o_DCmd;
  logic                  o_DRnW;
  logic [BEN-1:0]        o_DBen;
  logic [DATA_WIDTH-1:0] o_DData;
  logic [DATA_WIDTH-1:0] i_DData;
  logic                  i_DRdy;
  logic                  i_DErr;

  modport master (
    output o_DAddr, o_DCmd, o_DRnW, o_DBen, o_DData,
    input  i_DData, i_DRdy, i_DErr
  );

  modport slave (
    input  o_DAddr, o_DCmd, o_DRnW, o_DBen, o_DData,
    output i_DData, i_DRdy, i_DErr
  );
endinterface

// File: rtl/lsu_sbuf.sv
// -----------------------------------------------------------------------------
// lsu_sbuf - load-store unit with an in-order posted store buffer.
//
// Sits between the CPU memory stage and the D-Bus. Stores are posted into a
// FIFO and drained one bus transaction at a time; a load waits until the
// buffer is empty and the bus is idle, so program order is kept without
// forwarding. Loads are shifted down to bit 0 and sign/zero-extended. A bus
// transaction that sees neither i_DRdy nor i_DErr for TIMEOUT cycles is
// terminated as an error (TIMEOUT = 0 disables this).
//
//   clk, rst      clock; synchronous active-high reset
//   req_*         CPU request: valid/ready handshake, rnw, size, sext, addr,
//                 wdata (LSB-aligned)
//   err_align     combinational: current request is misaligned/unsupported
//   rsp_valid     1-cycle pulse, rdata holds the extended load result
//   err_bus       1-cycle pulse, load ended by bus error or timeout
//   err_store     1-cycle pulse, posted store ended by bus error or timeout
//   sb_empty      no buffered store and no store on the bus
//   dbus          D-Bus master port (see lsu_sbuf_if)
// -----------------------------------------------------------------------------
module lsu_sbuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SB_DEPTH   = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [1:0]            req_size,
  input  logic                  req_sext,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  err_align,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err_bus,
  output logic                  err_store,
  output logic                  sb_empty,
  lsu_sbuf_if.master            dbus
);

  localparam int BEN   = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BEN);
  localparam int PW    = $clog2(SB_DEPTH);
  localparam int CW    = PW + 1;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {B_IDLE, B_ST, B_LD} bus_state_e;

  // Byte-enable mask for an access of 2**size bytes starting at lane off.
  function automatic logic [BEN-1:0] size_ben(input logic [1:0] size,
                                              input logic [OFF_W-1:0] off);
    logic [BEN-1:0] m;
    for (int i = 0; i < BEN; i++) m[i] = (i < (1 << size));
    return m << off;
  endfunction

  bus_state_e            state_q, state_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  tmo_hit;
  logic                  issue_st, issue_ld, bus_done, xfer_fail;
  logic                  sb_pop, ld_fin;

  // Store buffer
  logic [ADDR_WIDTH-1:0] sb_addr_mem [SB_DEPTH];
  logic [BEN-1:0]        sb_ben_mem  [SB_DEPTH];
  logic [DATA_WIDTH-1:0] sb_data_mem [SB_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         sb_count;
  logic                  sb_full, sb_push;

  // Pending load
  logic                  ld_pending;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [1:0]            ld_size;
  logic                  ld_sext;
  logic                  ld_accept;
  logic [ADDR_WIDTH-1:0] ld_src_addr;
  logic [1:0]            ld_src_size;

  // Request decode
  logic                  misalign, accept;
  logic [OFF_W-1:0]      req_off;
  logic [BEN-1:0]        st_ben;
  logic [DATA_WIDTH-1:0] st_shift, st_data;

  // Load result path
  logic [DATA_WIDTH-1:0] ld_shift, ld_ext;
  logic                  ld_sign;
  int                    sz_bits;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default before the case,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      default: misalign = (DATA_WIDTH == 32) || (|req_addr[2:0]);
    endcase
  end

  assign sb_full   = (sb_count == CW'(SB_DEPTH));
  // A misaligned request is consumed immediately with no side effects.
  assign req_ready = misalign || (!ld_pending && (req_rnw || !sb_full));
  assign err_align = req_valid && misalign;
  assign accept    = req_valid && req_ready && !misalign;
  assign sb_push   = accept && !req_rnw;
  assign ld_accept = accept && req_rnw;
  assign req_off   = req_addr[OFF_W-1:0];

  // Stores are kept pre-shifted onto their bus lanes; unused lanes are zeroed
  // so stray upper bits of req_wdata never reach the bus.
  always_comb begin
    st_ben   = size_ben(req_size, req_off);
    st_shift = req_wdata << {req_off, 3'b000};
    st_data  = '0;
    for (int b = 0; b < BEN; b++)
      st_data[b*8 +: 8] = st_ben[b] ? st_shift[b*8 +: 8] : 8'h00;
  end

  // A load accepted while the bus is idle and the buffer empty goes straight
  // out from the request ports, which gives the one-cycle issue latency.
  assign ld_src_addr = ld_pending ? ld_addr : req_addr;
  assign ld_src_size = ld_pending ? ld_size : req_size;

  // ---------------------------------------------------------------------------
  // Load data extension (uses the captured load attributes)
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_shift = dbus.i_DData >> {ld_addr[OFF_W-1:0], 3'b000};
    sz_bits  = 8 << ld_size;
    ld_sign  = 1'b0;
    ld_ext   = '0;
    case (ld_size)
      2'd0:    ld_sign = ld_sext && ld_shift[7];
      2'd1:    ld_sign = ld_sext && ld_shift[15];
      2'd2:    ld_sign = ld_sext && ld_shift[31];
      default: ld_sign = 1'b0;
    endcase
    for (int i = 0; i < DATA_WIDTH; i++)
      ld_ext[i] = (i < sz_bits) ? ld_shift[i] : ld_sign;
  end

  // ---------------------------------------------------------------------------
  // Bus FSM: next state and control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    issue_st  = 1'b0;
    issue_ld  = 1'b0;
    bus_done  = 1'b0;
    xfer_fail = 1'b0;
    tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
    case (state_q)
      B_IDLE: begin
        tmo_d = '0;
        // Buffered stores always go first: an older store must reach memory
        // before any younger load is issued.
        if (sb_count != '0) begin
          state_d  = B_ST;
          issue_st = 1'b1;
        end else if (ld_pending || ld_accept) begin
          state_d  = B_LD;
          issue_ld = 1'b1;
        end
      end
      B_ST, B_LD: begin
        if (dbus.i_DRdy || dbus.i_DErr || tmo_hit) begin
          state_d   = B_IDLE;
          bus_done  = 1'b1;
          xfer_fail = dbus.i_DErr || tmo_hit;
          tmo_d     = '0;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  assign sb_pop   = bus_done && (state_q == B_ST);
  assign ld_fin   = bus_done && (state_q == B_LD);
  assign sb_empty = (sb_count == '0) && (state_q != B_ST);

  // ---------------------------------------------------------------------------
  // State, bus outputs, buffer pointers, load register, responses
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= B_IDLE;
      tmo_q        <= '0;
      dbus.o_DCmd  <= 1'b0;
      dbus.o_DRnW  <= 1'b0;
      dbus.o_DAddr <= '0;
      dbus.o_DBen  <= '0;
      dbus.o_DData <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      sb_count     <= '0;
      ld_pending   <= 1'b0;
      ld_addr      <= '0;
      ld_size      <= '0;
      ld_sext      <= 1'b0;
      rsp_valid    <= 1'b0;
      err_bus      <= 1'b0;
      err_store    <= 1'b0;
      rdata        <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;

      if (issue_st) begin
        dbus.o_DCmd  <= 1'b1;
        dbus.o_DRnW  <= 1'b0;
        dbus.o_DAddr <= sb_addr_mem[rd_ptr];
        dbus.o_DBen  <= sb_ben_mem[rd_ptr];
        dbus.o_DData <= sb_data_mem[rd_ptr];
      end else if (issue_ld) begin
        dbus.o_DCmd  <= 1'b1;
        dbus.o_DRnW  <= 1'b1;
        dbus.o_DAddr <= {ld_src_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        dbus.o_DBen  <= size_ben(ld_src_size, ld_src_addr[OFF_W-1:0]);
        dbus.o_DData <= '0;
      end else if (bus_done) begin
        dbus.o_DCmd  <= 1'b0;
        dbus.o_DRnW  <= 1'b0;
        dbus.o_DAddr <= '0;
        dbus.o_DBen  <= '0;
        dbus.o_DData <= '0;
      end

      if (sb_push) wr_ptr <= wr_ptr + 1'b1;
      if (sb_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({sb_push, sb_pop})
        2'b10:   sb_count <= sb_count + 1'b1;
        2'b01:   sb_count <= sb_count - 1'b1;
        default: sb_count <= sb_count;
      endcase

      if (ld_accept) begin
        ld_pending <= 1'b1;
        ld_addr    <= req_addr;
        ld_size    <= req_size;
        ld_sext    <= req_sext;
      end else if (ld_fin) begin
        ld_pending <= 1'b0;
      end

      rsp_valid <= ld_fin && !xfer_fail;
      err_bus   <= ld_fin && xfer_fail;
      err_store <= sb_pop && xfer_fail;
      if (ld_fin && !xfer_fail) rdata <= ld_ext;
    end
  end

  // NOTE: buffer storage has no reset; an entry is only read after it has been
  // written, and the pointers/count that qualify it are reset.
  always_ff @(posedge clk) begin
    if (sb_push) begin
      sb_addr_mem[wr_ptr] <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      sb_ben_mem[wr_ptr]  <= st_ben;
      sb_data_mem[wr_ptr] <= st_data;
    end
  end

endmodule

// File: tb/tb_lsu_sbuf.sv
// -----------------------------------------------------------------------------
// tb_lsu_sbuf - directed self-checking bench for lsu_sbuf (32-bit data,
// 4-entry store buffer, 8-cycle bus timeout). Bus transactions and load
// responses are logged by monitors and compared against expectations pushed
// when the stimulus is driven.
// -----------------------------------------------------------------------------
module tb_lsu_sbuf;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEN = DW / 8;
  localparam int SBD = 4;
  localparam int TMO = 8;

  typedef struct packed {
    logic           rnw;
    logic [AW-1:0]  addr;
    logic [BEN-1:0] ben;
    logic [DW-1:0]  data;
    logic           err;
  } bus_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_rnw, req_sext;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, err_align, rsp_valid, err_bus, err_store, sb_empty;
  logic [DW-1:0] rdata;

  logic          bus_en, bus_err;
  logic [DW-1:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int n_err_bus = 0;
  int n_err_store = 0;

  bus_t          bus_log[$], exp_bus[$];
  logic [DW-1:0] rsp_log[$], exp_rsp[$];

  always #5 clk = ~clk;

  lsu_sbuf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbus ();

  // Memory model: answers in the first command cycle when enabled.
  assign dbus.i_DRdy  = bus_en  & dbus.o_DCmd;
  assign dbus.i_DErr  = bus_err & dbus.o_DCmd;
  assign dbus.i_DData = mem_rdata;

  lsu_sbuf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SB_DEPTH(SBD), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rnw   (req_rnw),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .err_align (err_align),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err_bus   (err_bus),
    .err_store (err_store),
    .sb_empty  (sb_empty),
    .dbus      (dbus.master)
  );

  // Monitors sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (dbus.o_DCmd && (dbus.i_DRdy || dbus.i_DErr))
      bus_log.push_back(mk_bus(dbus.o_DRnW, dbus.o_DAddr, dbus.o_DBen,
                               dbus.o_DRnW ? '0 : dbus.o_DData, dbus.i_DErr));
    if (rsp_valid) rsp_log.push_back(rdata);
    if (err_bus)   n_err_bus++;
    if (err_store) n_err_store++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  function automatic bus_t mk_bus(input logic rnw, input logic [AW-1:0] addr,
                                  input logic [BEN-1:0] ben, input logic [DW-1:0] data,
                                  input logic err);
    bus_t t;
    t.rnw = rnw; t.addr = addr; t.ben = ben; t.data = data; t.err = err;
    return t;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rnw, input logic [1:0] size, input logic sext,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_valid = 1'b1; req_rnw = rnw; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
  endtask

  // Waits (bounded) for req_ready with the request held, then drops it after
  // the accepting edge. Returns at posedge+1 of the cycle after acceptance.
  task automatic wait_accept(input string tag, output int waited);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, req_ready, 1'b1);
    waited = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue(input string tag, input logic rnw, input logic [1:0] size,
                       input logic sext, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int w;
    drive(rnw, size, sext, addr, wdata);
    wait_accept(tag, w);
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sb_empty && req_ready && !dbus.o_DCmd) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_quiet"}, n < 200, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_nbus"}, bus_log.size(), exp_bus.size());
    while (exp_bus.size() > 0 && bus_log.size() > 0)
      check({tag, "_bus"}, bus_log.pop_front(), exp_bus.pop_front());
    check({tag, "_nrsp"}, rsp_log.size(), exp_rsp.size());
    while (exp_rsp.size() > 0 && rsp_log.size() > 0)
      check({tag, "_rsp"}, rsp_log.pop_front(), exp_rsp.pop_front());
    bus_log.delete(); exp_bus.delete(); rsp_log.delete(); exp_rsp.delete();
  endtask

  initial begin
    int  w, cnt, prev_eb, prev_es;
    logic seen;

    rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_size = 2'd0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; bus_en = 1'b1; bus_err = 1'b0; mem_rdata = '0;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",   req_ready,    1'b1);
    check("rst_rsp",     rsp_valid,    1'b0);
    check("rst_errs",    {err_bus, err_store}, 2'b00);
    check("rst_rdata",   rdata,        32'h0);
    check("rst_sbempty", sb_empty,     1'b1);
    check("rst_bus",     {dbus.o_DCmd, dbus.o_DRnW, dbus.o_DAddr, dbus.o_DBen, dbus.o_DData}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- 1: word load, zero-wait bus, latency T+2
    mem_rdata = 32'hDEADBEEF;
    drive(1'b1, 2'd2, 1'b0, 32'h100, '0);
    @(negedge clk);
    check("t1_ready_T",  req_ready,   1'b1);
    check("t1_align_T",  err_align,   1'b0);
    check("t1_cmd_T",    dbus.o_DCmd, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t1_cmd_T1",   {dbus.o_DCmd, dbus.o_DRnW, dbus.o_DAddr, dbus.o_DBen}, {1'b1, 1'b1, 32'h100, 4'hF});
    check("t1_rsp_T1",   rsp_valid,   1'b0);
    @(negedge clk);
    check("t1_rsp_T2",   rsp_valid,   1'b1);
    check("t1_rdata_T2", rdata,       32'hDEADBEEF);
    check("t1_cmd_T2",   dbus.o_DCmd, 1'b0);
    exp_bus.push_back(mk_bus(1'b1, 32'h100, 4'hF, '0, 1'b0));
    exp_rsp.push_back(32'hDEADBEEF);
    wait_quiet("t1");
    compare("t1");

    // ---- 2: sub-word loads with sign/zero extension
    mem_rdata = 32'h80000000;
    issue("t2a", 1'b1, 2'd0, 1'b1, 32'h103, '0);
    exp_bus.push_back(mk_bus(1'b1, 32'h100, 4'b1000, '0, 1'b0));
    exp_rsp.push_back(32'hFFFFFF80);
    wait_quiet("t2a");
    issue("t2b", 1'b1, 2'd0, 1'b0, 32'h103, '0);
    exp_bus.push_back(mk_bus(1'b1, 32'h100, 4'b1000, '0, 1'b0));
    exp_rsp.push_back(32'h00000080);
    wait_quiet("t2b");
    issue("t2c", 1'b1, 2'd1, 1'b1, 32'h102, '0);
    exp_bus.push_back(mk_bus(1'b1, 32'h100, 4'b1100, '0, 1'b0));
    exp_rsp.push_back(32'hFFFF8000);
    wait_quiet("t2c");
    compare("t2");

    // ---- 3: fill the buffer with the bus stalled; 5th store waits for a drain
    bus_en = 1'b0;
    issue("t3_s0", 1'b0, 2'd0, 1'b0, 32'h301, 32'h000000AB);
    issue("t3_s1", 1'b0, 2'd1, 1'b0, 32'h302, 32'h00001234);
    issue("t3_s2", 1'b0, 2'd2, 1'b0, 32'h304, 32'hCAFEF00D);
    issue("t3_s3", 1'b0, 2'd0, 1'b0, 32'h300, 32'hFFFFFF5A);
    drive(1'b0, 2'd2, 1'b0, 32'h308, 32'h00000055);
    @(negedge clk);
    check("t3_full_ready0", req_ready, 1'b0);
    check("t3_full_sbempty", sb_empty, 1'b0);
    @(negedge clk);
    check("t3_full_ready1", req_ready, 1'b0);
    @(posedge clk); #1;
    bus_en = 1'b1;
    wait_accept("t3_s4", w);
    check("t3_s4_waited", w > 0, 1'b1);
    exp_bus.push_back(mk_bus(1'b0, 32'h300, 4'b0010, 32'h0000AB00, 1'b0));
    exp_bus.push_back(mk_bus(1'b0, 32'h300, 4'b1100, 32'h12340000, 1'b0));
    exp_bus.push_back(mk_bus(1'b0, 32'h304, 4'b1111, 32'hCAFEF00D, 1'b0));
    exp_bus.push_back(mk_bus(1'b0, 32'h300, 4'b0001, 32'h0000005A, 1'b0));
    exp_bus.push_back(mk_bus(1'b0, 32'h308, 4'b1111, 32'h00000055, 1'b0));
    wait_quiet("t3");
    compare("t3");

    // ---- 4: store then load to the same address keeps program order
    mem_rdata = 32'h00000099;
    issue("t4_st", 1'b0, 2'd2, 1'b0, 32'h200, 32'h11223344);
    issue("t4_ld", 1'b1, 2'd2, 1'b0, 32'h200, '0);
    exp_bus.push_back(mk_bus(1'b0, 32'h200, 4'hF, 32'h11223344, 1'b0));
    exp_bus.push_back(mk_bus(1'b1, 32'h200, 4'hF, '0, 1'b0));
    exp_rsp.push_back(32'h00000099);
    wait_quiet("t4");
    compare("t4");

    // ---- 5: silent bus on a load -> timeout after TMO command cycles
    bus_en = 1'b0;
    prev_eb = n_err_bus;
    issue("t5", 1'b1, 2'd2, 1'b0, 32'h400, '0);
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dbus.o_DCmd) cnt++;
      if (err_bus) seen = 1'b1;
    end
    check("t5_errbus_seen", seen, 1'b1);
    check("t5_cmd_cycles", cnt, TMO);
    check("t5_rdata_kept", rdata, 32'h00000099);
    bus_en = 1'b1;
    wait_quiet("t5");
    check("t5_errbus_count", n_err_bus - prev_eb, 1);
    compare("t5");

    // ---- store terminated by i_DErr -> err_store, entry popped
    bus_err = 1'b1;
    prev_es = n_err_store;
    issue("ts_err", 1'b0, 2'd2, 1'b0, 32'h600, 32'h00000077);
    exp_bus.push_back(mk_bus(1'b0, 32'h600, 4'hF, 32'h00000077, 1'b1));
    wait_quiet("ts_err");
    bus_err = 1'b0;
    check("ts_err_count", n_err_store - prev_es, 1);
    check("ts_err_sbempty", sb_empty, 1'b1);
    compare("ts_err");

    // ---- 6: misaligned / unsupported requests are consumed with no effect
    drive(1'b0, 2'd1, 1'b0, 32'h101, 32'h0000BEEF);
    @(negedge clk);
    check("t6_h_align", {err_align, req_ready}, 2'b11);
    @(posedge clk); #1;
    drive(1'b1, 2'd2, 1'b0, 32'h102, '0);
    @(negedge clk);
    check("t6_w_align", {err_align, req_ready}, 2'b11);
    @(posedge clk); #1;
    drive(1'b1, 2'd3, 1'b0, 32'h108, '0);
    @(negedge clk);
    check("t6_d_align", {err_align, req_ready}, 2'b11);
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dbus.o_DCmd || !sb_empty || !req_ready) seen = 1'b1;
    end
    check("t6_no_activity", seen, 1'b0);
    @(posedge clk); #1;
    compare("t6_align");

    // ---- reset while a store is stalled on the bus
    bus_en = 1'b0;
    issue("t6_rst_st", 1'b0, 2'd2, 1'b0, 32'h500, 32'h0BADF00D);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dbus.o_DCmd) seen = 1'b1;
    end
    check("t6_rst_cmd_up", seen, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_cmd", dbus.o_DCmd, 1'b0);
    check("t6_rst_sbempty", sb_empty, 1'b1);
    repeat (3) @(negedge clk);
    check("t6_rst_stays_idle", {dbus.o_DCmd, sb_empty}, 2'b01);
    @(posedge clk); #1;
    bus_en = 1'b1;
    compare("t6_rst");

    // ---- recovery after reset: byte load, zero-extended
    mem_rdata = 32'h8001FF00;
    issue("t7", 1'b1, 2'd0, 1'b0, 32'h501, '0);
    exp_bus.push_back(mk_bus(1'b1, 32'h500, 4'b0010, '0, 1'b0));
    exp_rsp.push_back(32'h000000FF);
    wait_quiet("t7");
    compare("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
